// File: rtl/flash_device_model.sv
// Cycle-based model of a 16-bit command-set flash part: command decode, status register,
// timed program (bit-clearing) and block erase, registered read path onto a shared bus.
module flash_device_model #(
   parameter int FLASH_ADDR_SIZE  = 22,
   parameter int MEM_WORDS_LOG2   = 10,
   parameter int BLOCK_WORDS_LOG2 = 6,
   parameter int PROG_CYCLES      = 8,
   parameter int ERASE_CYCLES     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [FLASH_ADDR_SIZE:0] flash_addr,
   inout  wire  [15:0]              flash_data,
   input  logic [7:0]               flash_ctl,
   output logic                     dev_busy,
   output logic [2:0]               dbg_mode_o
);
   localparam int MEM_WORDS   = 1 << MEM_WORDS_LOG2;
   localparam int BLOCK_WORDS = 1 << BLOCK_WORDS_LOG2;
   localparam int BLK_W       = MEM_WORDS_LOG2 - BLOCK_WORDS_LOG2;
   localparam int MAX_CYCLES  = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
   localparam int CNT_W       = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      RD_ARRAY    = 3'd0,
      RD_STATUS   = 3'd1,
      PROG_SETUP  = 3'd2,
      ERASE_SETUP = 3'd3,
      BUSY_PROG   = 3'd4,
      BUSY_ERASE  = 3'd5
   } mode_e;

   mode_e                     mode_q;
   logic [7:0]                sr_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [15:0]               rd_q;
   logic [15:0]               rd_d;
   logic                      we_q;
   logic [MEM_WORDS_LOG2-1:0] paddr_q;
   logic [15:0]               pdata_q;
   logic [BLK_W-1:0]          blk_q;

   // Power-on contents of an erased part; reset deliberately never touches the array.
   logic [15:0] mem_q [MEM_WORDS] = '{default: 16'hFFFF};

   logic                      ce_n, oe, rp_n, vpen, we_n;
   logic                      selected, wr_evt, op_done, prog_commit, erase_commit;
   logic [MEM_WORDS_LOG2-1:0] widx;
   logic [7:0]                cmd;
   logic                      unused_bits;

   assign ce_n = flash_ctl[6];
   assign oe   = flash_ctl[3];
   assign rp_n = flash_ctl[2];
   assign vpen = flash_ctl[1];
   assign we_n = flash_ctl[0];

   assign selected     = ~ce_n & rp_n;
   assign wr_evt       = ~we_q & we_n & selected & oe;
   assign widx         = flash_addr[MEM_WORDS_LOG2:1];
   assign cmd          = flash_data[7:0];
   assign op_done      = (cnt_q <= CNT_W'(1));
   assign prog_commit  = (mode_q == BUSY_PROG) && op_done && rp_n;
   assign erase_commit = (mode_q == BUSY_ERASE) && op_done && rp_n;
   assign dev_busy     = (mode_q == BUSY_PROG) || (mode_q == BUSY_ERASE);
   assign dbg_mode_o   = mode_q;
   assign flash_data   = (selected && !oe) ? rd_q : 16'hzzzz;
   assign unused_bits  = ^{flash_ctl[7], flash_ctl[5:4], flash_addr[0],
                           flash_addr[FLASH_ADDR_SIZE:MEM_WORDS_LOG2+1]};

   always_comb begin
      rd_d = {8'h00, sr_q};
      if (mode_q == RD_ARRAY) rd_d = mem_q[widx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= RD_ARRAY;
         sr_q    <= 8'h80;
         cnt_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b1;
         paddr_q <= '0;
         pdata_q <= '0;
         blk_q   <= '0;
      end else begin
         we_q <= we_n;
         rd_q <= rd_d;
         if (!rp_n) begin
            mode_q <= RD_ARRAY;
            sr_q   <= 8'h80;
            cnt_q  <= '0;
         end else begin
            case (mode_q)
               RD_ARRAY, RD_STATUS: begin
                  if (wr_evt) begin
                     case (cmd)
                        8'hFF:        mode_q <= RD_ARRAY;
                        8'h70:        mode_q <= RD_STATUS;
                        8'h40, 8'h10: mode_q <= PROG_SETUP;
                        8'h20:        mode_q <= ERASE_SETUP;
                        8'h50:        sr_q[5:3] <= 3'b000;
                        default:      ;
                     endcase
                  end
               end
               PROG_SETUP: begin
                  if (wr_evt) begin
                     if (!vpen) begin
                        sr_q[4] <= 1'b1;
                        sr_q[3] <= 1'b1;
                        mode_q  <= RD_STATUS;
                     end else begin
                        paddr_q <= widx;
                        pdata_q <= flash_data;
                        cnt_q   <= CNT_W'(PROG_CYCLES);
                        sr_q[7] <= 1'b0;
                        mode_q  <= BUSY_PROG;
                     end
                  end
               end
               ERASE_SETUP: begin
                  if (wr_evt) begin
                     if (cmd != 8'hD0) begin
                        sr_q[5] <= 1'b1;
                        sr_q[4] <= 1'b1;
                        mode_q  <= RD_STATUS;
                     end else if (!vpen) begin
                        sr_q[5] <= 1'b1;
                        sr_q[3] <= 1'b1;
                        mode_q  <= RD_STATUS;
                     end else begin
                        blk_q   <= widx[MEM_WORDS_LOG2-1:BLOCK_WORDS_LOG2];
                        cnt_q   <= CNT_W'(ERASE_CYCLES);
                        sr_q[7] <= 1'b0;
                        mode_q  <= BUSY_ERASE;
                     end
                  end
               end
               BUSY_PROG, BUSY_ERASE: begin
                  // Host writes are dropped here; only the countdown advances.
                  cnt_q <= op_done ? '0 : cnt_q - 1'b1;
                  if (op_done) begin
                     sr_q[7] <= 1'b1;
                     mode_q  <= RD_STATUS;
                  end
               end
               default: mode_q <= RD_ARRAY;
            endcase
         end
      end
   end

   // The whole update lands on the final busy cycle, so an abort leaves the array intact.
   always_ff @(posedge clk) begin
      if (prog_commit) mem_q[paddr_q] <= mem_q[paddr_q] & pdata_q;
      if (erase_commit) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            mem_q[{blk_q, BLOCK_WORDS_LOG2'(i)}] <= 16'hFFFF;
         end
      end
   end

endmodule

// File: tb/tb_flash_device_model.sv
// Directed bench for flash_device_model: bus reads and busy pulses are checked by
// monitors against queues of expected values filled by the stimulus tasks.
module tb_flash_device_model;
   localparam int PROG_CYCLES  = 8;
   localparam int ERASE_CYCLES = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [22:0] flash_addr;
   wire  [15:0] flash_data;
   logic [15:0] host_data;
   logic        ce_n, oe, rp_n, vpen, we_n;
   logic [7:0]  flash_ctl;
   logic        dev_busy;
   logic [2:0]  dbg_mode;

   always #5 clk = ~clk;

   assign flash_ctl  = {1'b0, ce_n, 1'b1, 1'b0, oe, rp_n, vpen, we_n};
   assign flash_data = oe ? host_data : 16'hzzzz;

   flash_device_model #(
      .FLASH_ADDR_SIZE (22),
      .MEM_WORDS_LOG2  (10),
      .BLOCK_WORDS_LOG2(6),
      .PROG_CYCLES     (PROG_CYCLES),
      .ERASE_CYCLES    (ERASE_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flash_addr(flash_addr),
      .flash_data(flash_data),
      .flash_ctl (flash_ctl),
      .dev_busy  (dev_busy),
      .dbg_mode_o(dbg_mode)
   );

   // Scoreboard state: each read entry is {dev_busy, flash_data}.
   logic [16:0] exp_q[$];
   string       nm_q[$];
   int          bexp_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic        chk_en    = 1'b0;
   int          busy_len  = 0;
   logic [16:0] mon_exp;
   string       mon_nm;
   int          mon_blen;

   always @(negedge clk) begin
      if (chk_en) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_sample: got %h, no expected entry queued", {dev_busy, flash_data});
         end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = nm_q.pop_front();
            if ({dev_busy, flash_data} === mon_exp) pass_cnt++;
            else $display("FAIL %s: got busy/data %h, expected %h", mon_nm, {dev_busy, flash_data}, mon_exp);
         end
      end
   end

   always @(negedge clk) begin
      if (dev_busy === 1'b1) begin
         busy_len++;
      end else if (busy_len != 0) begin
         total_cnt++;
         if (bexp_q.size() == 0) begin
            $display("FAIL unexpected_busy: got busy pulse of %0d clk, none expected", busy_len);
         end else begin
            mon_blen = bexp_q.pop_front();
            if (busy_len == mon_blen) pass_cnt++;
            else $display("FAIL busy_length: got %0d clk, expected %0d clk", busy_len, mon_blen);
         end
         busy_len = 0;
      end
   end

   task automatic wr(input logic [22:0] a, input logic [15:0] d, input logic vp);
      flash_addr = a;
      host_data  = d;
      vpen       = vp;
      oe         = 1'b1;
      we_n       = 1'b0;
      @(posedge clk); #1;
      we_n = 1'b1;
      @(posedge clk); #1;
      vpen = 1'b1;
   endtask

   task automatic rd(input logic [22:0] a, input logic [16:0] e, input string n);
      flash_addr = a;
      oe         = 1'b0;
      exp_q.push_back(e);
      nm_q.push_back(n);
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk); #1;
      chk_en = 1'b0;
   endtask

   task automatic wait_idle(input string n);
      int k = 0;
      while (dev_busy === 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (dev_busy !== 1'b0) begin
         total_cnt++;
         $display("FAIL %s_timeout: dev_busy still %b (mode %0d), expected 0", n, dev_busy, dbg_mode);
      end
   endtask

   task automatic prog(input logic [22:0] a, input logic [15:0] d, input string n);
      wr(a, 16'h0040, 1'b1);
      bexp_q.push_back(PROG_CYCLES);
      wr(a, d, 1'b1);
      wait_idle(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      ce_n       = 1'b0;
      oe         = 1'b0;
      rp_n       = 1'b1;
      vpen       = 1'b1;
      we_n       = 1'b1;
      flash_addr = '0;
      host_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rd(23'd10, {1'b0, 16'h0000}, "reset_rd_q");
      rst_n = 1'b1;

      wr(23'd10, 16'h00FF, 1'b1);
      rd(23'd10, {1'b0, 16'hFFFF}, "rd_array_init");
      wr(23'd10, 16'h0033, 1'b1);
      rd(23'd10, {1'b0, 16'hFFFF}, "ignored_cmd");

      wr(23'd10, 16'h0040, 1'b1);
      bexp_q.push_back(PROG_CYCLES);
      wr(23'd10, 16'h1234, 1'b1);
      for (int i = 0; i < PROG_CYCLES - 1; i++) rd(23'd10, {1'b1, 16'h0000}, "prog_busy_sr");
      wait_idle("prog1");
      rd(23'd10, {1'b0, 16'h0080}, "prog_done_sr");
      wr(23'd10, 16'h00FF, 1'b1);
      rd(23'd10, {1'b0, 16'h1234}, "prog_word5");
      rd(23'd12, {1'b0, 16'hFFFF}, "word6_untouched");

      prog(23'd10, 16'hFF0F, "prog2");
      wr(23'd10, 16'h00FF, 1'b1);
      rd(23'd10, {1'b0, 16'h1204}, "prog_and");

      prog(23'd128, 16'h00F0, "prog64");
      prog(23'd126, 16'hAAAA, "prog63");
      wr(23'd10, 16'h00FF, 1'b1);
      rd(23'd126, {1'b0, 16'hAAAA}, "word63_prog");

      wr(23'd10, 16'h0020, 1'b1);
      bexp_q.push_back(ERASE_CYCLES);
      wr(23'd10, 16'h00D0, 1'b1);
      for (int i = 0; i < 3; i++) rd(23'd10, {1'b1, 16'h0000}, "erase_busy_sr");
      wait_idle("erase");
      rd(23'd10, {1'b0, 16'h0080}, "erase_done_sr");
      wr(23'd10, 16'h00FF, 1'b1);
      for (int i = 0; i < 64; i++) rd(23'(i * 2), {1'b0, 16'hFFFF}, "erase_block");
      rd(23'd128, {1'b0, 16'h00F0}, "erase_word64_kept");

      wr(23'd10, 16'h0020, 1'b1);
      wr(23'd10, 16'h0055, 1'b1);
      rd(23'd10, {1'b0, 16'h00B0}, "erase_seq_err");
      wr(23'd10, 16'h0050, 1'b1);
      rd(23'd10, {1'b0, 16'h0080}, "clear_sr");

      wr(23'd128, 16'h0040, 1'b1);
      wr(23'd128, 16'h0000, 1'b0);
      rd(23'd128, {1'b0, 16'h0098}, "vpen_err");
      wr(23'd128, 16'h0050, 1'b1);
      wr(23'd128, 16'h00FF, 1'b1);
      rd(23'd128, {1'b0, 16'h00F0}, "vpen_array_kept");

      ce_n = 1'b1;
      wr(23'd10, 16'h0070, 1'b1);
      ce_n = 1'b0;
      rd(23'd10, {1'b0, 16'hFFFF}, "deselect_ignored");

      prog(23'd10, 16'h0F0F, "prog_pre_reset");
      wr(23'd10, 16'h0020, 1'b1);
      bexp_q.push_back(10);
      wr(23'd10, 16'h00D0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr(23'd10, 16'h0070, 1'b1);
      rd(23'd10, {1'b0, 16'h0080}, "sr_after_reset");
      wr(23'd10, 16'h00FF, 1'b1);
      rd(23'd10, {1'b0, 16'h0F0F}, "reset_block_kept");

      wr(23'd12, 16'h0040, 1'b1);
      bexp_q.push_back(4);
      wr(23'd12, 16'h0000, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rp_n = 1'b0;
      @(posedge clk); #1;
      rp_n = 1'b1;
      rd(23'd12, {1'b0, 16'hFFFF}, "rp_abort_kept");
      wr(23'd12, 16'h0070, 1'b1);
      rd(23'd12, {1'b0, 16'h0080}, "rp_abort_sr");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0 || bexp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL leftover_expected: got %0d reads / %0d busy entries unconsumed, expected 0/0",
                  exp_q.size(), bexp_q.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/flash_device_model.md
FLASH_DEVICE_MODEL -- requirements
Module: flash_device_model

Interface
REQ-001 The module SHALL take parameters: FLASH_ADDR_SIZE, default 22, word-address width; MEM_WORDS_LOG2, default 10, modelled array depth (log2 words); BLOCK_WORDS_LOG2, default 6, erase block size (log2 words); PROG_CYCLES, default 8, program busy time in clk; ERASE_CYCLES, default 64, erase busy time in clk.
REQ-002 Ports: clk  input  1  sole clock, all state on posedge.
REQ-003 Ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: flash_addr  input  FLASH_ADDR_SIZE+1  byte address; bit 0 ignored; word index = flash_addr[MEM_WORDS_LOG2:1], upper bits alias.
REQ-005 Ports: flash_data  inout  16  bidirectional data bus.
REQ-006 Ports: flash_ctl  input  8  {byte[7], ce_n[6], ce1[5], ce2[4], oe[3], rp_n[2], vpen[1], we_n[0]}; oe=1 means host drives the bus, oe=0 means the device drives it.
REQ-007 Ports: dev_busy  output  1  high while a program or erase operation is in progress.

Function
REQ-008 Selected SHALL mean ce_n=0 and rp_n=1; byte, ce1 and ce2 SHALL be ignored.
REQ-009 Write event: registered copy we_q of we_n; event when we_q=0, we_n=1, selected, oe=1; data and address SHALL be those sampled on that same edge.
REQ-010 Modes: RD_ARRAY, RD_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE.
REQ-011 In RD_ARRAY/RD_STATUS, write event 0xFF->RD_ARRAY, 0x70->RD_STATUS, 0x40 or 0x10->PROG_SETUP, 0x20->ERASE_SETUP, 0x50->clear SR[5:3] and keep mode; any other value is ignored.
REQ-012 PROG_SETUP: next write event SHALL latch addr/data and enter BUSY_PROG with counter=PROG_CYCLES, unless vpen=0, in which case SR[4] and SR[3] are set and the mode becomes RD_STATUS.
REQ-013 ERASE_SETUP: next write event 0xD0 SHALL latch block address and enter BUSY_ERASE with counter=ERASE_CYCLES (vpen=0: set SR[5] and SR[3], go RD_STATUS); any other value SHALL set SR[5] and SR[4] and go RD_STATUS.
REQ-014 BUSY_*: counter decrements each clk; the array update is applied in the cycle the counter reaches 0, then mode=RD_STATUS and SR[7]=1.
REQ-015 Program SHALL store mem[a] <= mem[a] & data (bits only clear 1->0).
REQ-016 Erase SHALL write 0xFFFF to all 2^BLOCK_WORDS_LOG2 words of the addressed block; one word per cycle is permitted provided the total busy time is at least ERASE_CYCLES.
REQ-017 Write events during BUSY_* SHALL be ignored.
REQ-018 SR SHALL be 8 bits zero-extended to 16 on read: SR[7] ready (0 while busy), SR[5] erase/sequence error, SR[4] program/sequence error, SR[3] vpen error, other bits 0.
REQ-019 Read data register rd_q SHALL update every clk: status when mode is RD_STATUS, BUSY_* or *_SETUP, else mem[word index]; latency is 1 clk from an address or mode change.
REQ-020 flash_data SHALL be driven with rd_q when selected and oe=0, else high-Z.
REQ-021 dev_busy SHALL equal 1 exactly in BUSY_PROG and BUSY_ERASE.
REQ-022 rp_n=0 sampled on clk SHALL abort any operation without an array update, set mode=RD_ARRAY and SR=0x80.

Reset
REQ-023 rst_n=0 SHALL asynchronously set mode=RD_ARRAY, SR=0x80, counter=0, rd_q=0, we_q=1, dev_busy=0; array contents are not altered.
REQ-024 Reset during BUSY_* SHALL leave the target word or block unchanged.
REQ-025 The array SHALL initialise to 0xFFFF at time zero for simulation.

Verification
REQ-026 After reset, write 0xFF, addr word 5, oe=0 -> flash_data=0xFFFF after 1 clk.
REQ-027 Write 0x40 then 0x1234 at word 5 -> dev_busy=1 for PROG_CYCLES clk, SR reads 0x0000 meanwhile then 0x0080; after 0xFF, word 5 reads 0x1234.
REQ-028 Program 0xFF0F onto word 5 holding 0x1234 -> reads 0x1204.
REQ-029 Write 0x20 then 0xD0 at word 5 -> dev_busy held ERASE_CYCLES clk; words 0..63 read 0xFFFF, word 64 unchanged.
REQ-030 Write 0x20 then 0x55 -> SR=0x00B0, no busy; 0x50 -> SR=0x0080.
REQ-031 Write 0x40, data with vpen=0 -> SR=0x0098, array unchanged; rst_n pulse mid-erase -> SR=0x0080, block unchanged.
